// File: rtl/cpu_step_display_if.sv
// CPU observation bundle: debug outputs from the CPU, step clock back to it.
// master = CPU side, slave = board display side.
interface cpu_step_display_if;
  logic [31:0] currentPC;
  logic [31:0] nextPC;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] ALUResult;
  logic [31:0] DMOut;
  logic        cpu_clk;

  modport master (
    output currentPC, nextPC, rs, rt,
    output ReadData1, ReadData2,
    output ALUResult, DMOut,
    input  cpu_clk
  );

  modport slave (
    input  currentPC, nextPC, rs, rt,
    input  ReadData1, ReadData2,
    input  ALUResult, DMOut,
    output cpu_clk
  );
endinterface

// File: rtl/cpu_step_display.sv
// Single-step clock from a debounced button, plus a 4-digit hex
// multiplexed 7-segment view of selected CPU debug values.
module cpu_step_display #(
  parameter int DEB_CYCLES = 200000,
  parameter int SCAN_DIV   = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       step_btn,
  input  logic [1:0] sel,
  cpu_step_display_if.slave cpu,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int DW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DEB_MAX =
    DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_MAX =
    SW'(SCAN_DIV - 1);

  logic          btn_s1;
  logic          btn_s2;
  logic          btn_acc;
  logic [DW-1:0] deb_cnt;
  logic          deb_diff;
  logic          deb_flip;
  logic          cpu_clk_q;

  logic [SW-1:0] scan_cnt;
  logic          scan_wrap;
  logic [1:0]    digit;
  logic          started;
  logic [15:0]   display;
  logic [15:0]   sel_val;
  logic [3:0]    nib;
  logic [7:0]    seg_nxt;

  // Only the low bytes are displayed; the rest is left unobserved.
  logic unused_bits;
  assign unused_bits = ^{
    cpu.currentPC[31:8], cpu.nextPC[31:8],
    cpu.ReadData1[31:8], cpu.ReadData2[31:8],
    cpu.ALUResult[31:8], cpu.DMOut[31:8]
  };

  // Two-flop synchroniser for the raw button.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= step_btn;
      btn_s2 <= btn_s1;
    end
  end

  assign deb_diff = btn_s2 != btn_acc;
  assign deb_flip = deb_diff && (deb_cnt == DEB_MAX);

  // Accept a new level only after it persists DEB_CYCLES cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      deb_cnt <= '0;
      btn_acc <= 1'b0;
    end else if (deb_flip) begin
      deb_cnt <= '0;
      btn_acc <= btn_s2;
    end else if (deb_diff) begin
      deb_cnt <= deb_cnt + DW'(1);
    end else begin
      deb_cnt <= '0;
    end
  end

  // One-cycle step pulse on an accepted press only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cpu_clk_q <= 1'b0;
    else     cpu_clk_q <= deb_flip & btn_s2;
  end

  assign cpu.cpu_clk = cpu_clk_q;

  assign scan_wrap = scan_cnt == SCAN_MAX;

  // Digit dwell counter and digit index.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Value chosen by the select switches.
  always_comb begin
    sel_val = 16'h0000;
    case (sel)
      2'b00: sel_val = {cpu.currentPC[7:0],
                        cpu.nextPC[7:0]};
      2'b01: sel_val = {3'b000, cpu.rs,
                        cpu.ReadData1[7:0]};
      2'b10: sel_val = {3'b000, cpu.rt,
                        cpu.ReadData2[7:0]};
      default: sel_val = {cpu.ALUResult[7:0],
                          cpu.DMOut[7:0]};
    endcase
  end

  // Snapshot once per full scan so all four digits agree.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      started <= 1'b0;
      display <= 16'h0000;
    end else begin
      started <= 1'b1;
      if (!started || (scan_wrap && digit == 2'd3))
        display <= sel_val;
    end
  end

  assign nib = display[{digit, 2'b00} +: 4];

  // Hex to active-low segments, dp off.
  always_comb begin
    seg_nxt = 8'hFF;
    case (nib)
      4'h0: seg_nxt = 8'hC0;
      4'h1: seg_nxt = 8'hF9;
      4'h2: seg_nxt = 8'hA4;
      4'h3: seg_nxt = 8'hB0;
      4'h4: seg_nxt = 8'h99;
      4'h5: seg_nxt = 8'h92;
      4'h6: seg_nxt = 8'h82;
      4'h7: seg_nxt = 8'hF8;
      4'h8: seg_nxt = 8'h80;
      4'h9: seg_nxt = 8'h90;
      4'hA: seg_nxt = 8'h88;
      4'hB: seg_nxt = 8'h83;
      4'hC: seg_nxt = 8'hC6;
      4'hD: seg_nxt = 8'hA1;
      4'hE: seg_nxt = 8'h86;
      default: seg_nxt = 8'h8E;
    endcase
  end

  // Register enables and segments together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else begin
      an  <= ~(4'b0001 << digit);
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_step_display.sv
// Bench for cpu_step_display: per-cycle reference model plus
// pinned literal expectations for latency and display content.
module tb_cpu_step_display;

  localparam int DEB  = 8;
  localparam int SCAN = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       step_btn = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [3:0] an;
  logic [7:0] seg;

  cpu_step_display_if dbg ();

  cpu_step_display #(
    .DEB_CYCLES(DEB),
    .SCAN_DIV(SCAN)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .step_btn(step_btn),
    .sel(sel),
    .cpu(dbg.slave),
    .an(an),
    .seg(seg)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  logic [7:0] hex_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] sel_value();
    case (sel)
      2'b00: return {dbg.currentPC[7:0],
                     dbg.nextPC[7:0]};
      2'b01: return {3'b000, dbg.rs,
                     dbg.ReadData1[7:0]};
      2'b10: return {3'b000, dbg.rt,
                     dbg.ReadData2[7:0]};
      default: return {dbg.ALUResult[7:0],
                       dbg.DMOut[7:0]};
    endcase
  endfunction

  // Reference model: edge m after reset release samples the inputs.
  logic        samp [8192];
  logic [15:0] vals [8192];

  initial begin : model
    int m;
    logic acc;
    logic flip;
    logic v;
    logic e_clk;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic [15:0] disp;
    int k;
    int ld;
    m = 0;
    acc = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        m = 0;
        acc = 1'b0;
        e_clk = 1'b0;
        e_an = 4'hF;
        e_seg = 8'hFF;
      end else begin
        if (m < 8191) m++;
        samp[m] = step_btn;
        vals[m] = sel_value();
        // Synced level at edge m is the sample from edge m-2;
        // a flip needs DEB consecutive differing levels.
        flip = 1'b1;
        for (int j = m - DEB - 1; j <= m - 2; j++) begin
          v = (j >= 1) ? samp[j] : 1'b0;
          if (v == acc) flip = 1'b0;
        end
        e_clk = flip && !acc;
        if (flip) acc = ~acc;
        if (m == 1) begin
          disp = 16'h0000;
        end else begin
          ld = ((m - 1) / (4 * SCAN)) * (4 * SCAN);
          if (ld == 0) ld = 1;
          disp = vals[ld];
        end
        k = ((m - 1) / SCAN) % 4;
        e_an = ~(4'b0001 << k);
        e_seg = hex_tab[disp[4*k +: 4]];
      end
      chk("model_cpu_clk", {31'b0, dbg.cpu_clk},
          {31'b0, e_clk});
      chk("model_an", {28'b0, an}, {28'b0, e_an});
      chk("model_seg", {24'b0, seg}, {24'b0, e_seg});
    end
  end

  always @(negedge CLK)
    if (!RST && dbg.cpu_clk) pulses++;

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic pin_digit(input string nm,
                           input logic [3:0] ean,
                           input logic [7:0] eseg);
    chk({nm, "_an"}, {28'b0, an}, {28'b0, ean});
    chk({nm, "_seg"}, {24'b0, seg}, {24'b0, eseg});
  endtask

  initial begin : stim
    int p0;
    int first;
    int run;
    logic hit;
    logic [3:0] an_tab [4];
    logic [7:0] sg_tab [4];
    dbg.currentPC = 32'h0;
    dbg.nextPC = 32'h0;
    dbg.rs = 5'd0;
    dbg.rt = 5'd0;
    dbg.ReadData1 = 32'h0;
    dbg.ReadData2 = 32'h0;
    dbg.ALUResult = 32'h0;
    dbg.DMOut = 32'h0;
    repeat (3) tick();
    pin_digit("reset", 4'hF, 8'hFF);
    chk("reset_clk", {31'b0, dbg.cpu_clk}, 32'd0);
    RST = 1'b0;
    tick();
    pin_digit("first", 4'hE, 8'hC0);

    // Press and hold: one pulse, ten cycles in.
    p0 = pulses;
    first = 0;
    step_btn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (dbg.cpu_clk && first == 0) first = i;
    end
    chk("press_latency", first, 10);
    chk("press_count", pulses - p0, 1);
    p0 = pulses;
    step_btn = 1'b0;
    repeat (40) tick();
    chk("release_count", pulses - p0, 0);

    // Bounce shorter than the debounce window.
    p0 = pulses;
    for (int i = 0; i < 30; i++) begin
      step_btn = ((i / 3) % 2) == 0;
      tick();
    end
    step_btn = 1'b0;
    repeat (20) tick();
    chk("bounce_count", pulses - p0, 0);

    // PC display scan.
    sel = 2'b00;
    dbg.currentPC = 32'h0000_0004;
    dbg.nextPC = 32'h0000_0008;
    an_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
    sg_tab = '{8'h80, 8'hC0, 8'h99, 8'hC0};
    do_reset();
    tick();
    pin_digit("scan_t1", 4'hE, 8'hC0);
    for (int t = 2; t <= 16; t++) begin
      tick();
      pin_digit("scan", an_tab[(t - 1) / 4],
                sg_tab[(t - 1) / 4]);
    end

    // rs / ReadData1 display: 1FEF.
    sel = 2'b01;
    dbg.rs = 5'd31;
    dbg.ReadData1 = 32'hDEAD_BEEF;
    sg_tab = '{8'h8E, 8'h86, 8'h8E, 8'hF9};
    do_reset();
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t % 4 == 0)
        pin_digit("rs_disp", an_tab[(t - 1) / 4],
                  sg_tab[(t - 1) / 4]);
    end

    // Select change mid-scan waits for the wrap.
    sel = 2'b00;
    dbg.ALUResult = 32'h1234_56AB;
    dbg.DMOut = 32'h9876_54CD;
    do_reset();
    repeat (6) tick();
    sel = 2'b11;
    repeat (6) tick();
    pin_digit("hold_old", 4'hB, 8'h99);
    sg_tab = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    for (int t = 13; t <= 32; t++) begin
      tick();
      if (t >= 20 && t % 4 == 0)
        pin_digit("new_disp", an_tab[(t - 17) / 4],
                  sg_tab[(t - 17) / 4]);
    end

    // Reset during a step pulse.
    step_btn = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (dbg.cpu_clk) hit = 1'b1;
    end
    chk("pulse_seen", {31'b0, hit}, 32'd1);
    RST = 1'b1;
    #1;
    chk("rst_pulse_clk", {31'b0, dbg.cpu_clk}, 32'd0);
    pin_digit("rst_pulse", 4'hF, 8'hFF);
    step_btn = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    p0 = pulses;
    repeat (40) tick();
    chk("rst_pulse_after", pulses - p0, 0);

    // Reset during a debounce count.
    step_btn = 1'b1;
    repeat (5) tick();
    RST = 1'b1;
    #1;
    pin_digit("rst_deb", 4'hF, 8'hFF);
    step_btn = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    p0 = pulses;
    repeat (30) tick();
    chk("rst_deb_after", pulses - p0, 0);

    // Random traffic against the model.
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        step_btn = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 14);
      end
      run--;
      if ($urandom_range(0, 49) == 0) begin
        sel = 2'($urandom_range(0, 3));
        dbg.currentPC = $urandom;
        dbg.nextPC = $urandom;
        dbg.rs = 5'($urandom);
        dbg.rt = 5'($urandom);
        dbg.ReadData1 = $urandom;
        dbg.ReadData2 = $urandom;
        dbg.ALUResult = $urandom;
        dbg.DMOut = $urandom;
      end
      RST = ($urandom_range(0, 999) == 0);
      tick();
    end
    RST = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
